// File: rtl/alu_multiciclo.sv
// -----------------------------------------------------------------------------
// alu_multiciclo
//
// Multi-cycle ALU for the EX stage of the RISC-V datapath. Logical and
// arithmetic operations finish on the accept edge. Shifts are iterative and
// move one bit per clock by default.
//
// Build option:
//   ALU_BARREL_EN : when defined, shifts use a combinational barrel shifter.
//                   Every operation then goes IDLE -> DONE in one edge, and
//                   the EXEC state is never entered.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST_n      in   synchronous active-low reset
//   ALUSELECT  in   [3:0] operation code (0000..1001 legal, others illegal)
//   OP_A       in   [WIDTH-1:0] operand A / value to shift
//   OP_B       in   [WIDTH-1:0] operand B; OP_B[SHW-1:0] is the shift amount
//   VALID_IN   in   request valid
//   READY_OUT  out  unit idle, can accept a request
//   RESULT     out  [WIDTH-1:0] result, held while VALID_OUT=1
//   ZERO       out  RESULT == 0
//   ILEGAL     out  last executed code was unsupported
//   VALID_OUT  out  result valid
//   READY_IN   in   downstream consumes the result
// -----------------------------------------------------------------------------
module alu_multiciclo #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [3:0]       ALUSELECT,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             ILEGAL,
    output logic             VALID_OUT,
    input  logic             READY_IN
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ilegal_q, ilegal_d;

`ifndef ALU_BARREL_EN
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
`endif

    function automatic logic is_illegal(input logic [3:0] op);
        return (op > OP_SRA);
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Single-edge result. Shift codes only produce a value here in the barrel
    // build; in the iterative build they never reach this function's output.
    function automatic logic [WIDTH-1:0] alu_comb(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        logic [WIDTH-1:0]        r;
        a_s = a;
        b_s = b;
        r   = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_BARREL_EN
            OP_SLL:  r = a << b[SHW-1:0];
            OP_SRL:  r = a >> b[SHW-1:0];
            OP_SRA:  r = a_s >>> b[SHW-1:0];
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

`ifndef ALU_BARREL_EN
    // One-bit shift step; SRA keeps the sign bit in place.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] v
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {1'b0, v[WIDTH-1:1]};
        endcase
        return r;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ilegal_d = ilegal_q;
`ifndef ALU_BARREL_EN
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (VALID_IN) begin
`ifndef ALU_BARREL_EN
                    if (is_shift(ALUSELECT)) begin
                        shreg_d = OP_A;
                        cnt_d   = OP_B[SHW-1:0];
                        op_d    = ALUSELECT;
                        state_d = EXEC;
                    end else
`endif
                    begin
                        result_d = alu_comb(ALUSELECT, OP_A, OP_B);
                        zero_d   = (alu_comb(ALUSELECT, OP_A, OP_B) == '0);
                        ilegal_d = is_illegal(ALUSELECT);
                        state_d  = DONE;
                    end
                end
            end
`ifndef ALU_BARREL_EN
            EXEC: begin
                if (cnt_q != '0) begin
                    shreg_d = shift_step(op_q, shreg_q);
                    cnt_d   = cnt_q - SHW'(1);
                end else begin
                    result_d = shreg_q;
                    zero_d   = (shreg_q == '0);
                    ilegal_d = 1'b0;
                    state_d  = DONE;
                end
            end
`endif
            DONE: begin
                if (READY_IN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            ilegal_q <= 1'b0;
`ifndef ALU_BARREL_EN
            cnt_q    <= '0;
            shreg_q  <= '0;
            op_q     <= OP_ADD;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ilegal_q <= ilegal_d;
`ifndef ALU_BARREL_EN
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            op_q     <= op_d;
`endif
        end
    end

    assign READY_OUT = (state_q == IDLE);
    assign VALID_OUT = (state_q == DONE);
    assign RESULT    = result_q;
    assign ZERO      = zero_q;
    assign ILEGAL    = ilegal_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_alu_multiciclo
//
// Directed bench for alu_multiciclo. Inputs change 1 time unit after the
// rising edge, outputs are sampled at the same point. Shift timing is given
// as the number of edges after the accept edge until VALID_OUT rises.
// -----------------------------------------------------------------------------
module tb_alu_multiciclo;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic [3:0]  ALUSELECT;
    logic [31:0] OP_A;
    logic [31:0] OP_B;
    logic        VALID_IN;
    logic        READY_OUT;
    logic [31:0] RESULT;
    logic        ZERO;
    logic        ILEGAL;
    logic        VALID_OUT;
    logic        READY_IN;

    int n_checks = 0;
    int n_fail   = 0;

    alu_multiciclo #(.WIDTH(32), .SHW(5)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .ALUSELECT (ALUSELECT),
        .OP_A      (OP_A),
        .OP_B      (OP_B),
        .VALID_IN  (VALID_IN),
        .READY_OUT (READY_OUT),
        .RESULT    (RESULT),
        .ZERO      (ZERO),
        .ILEGAL    (ILEGAL),
        .VALID_OUT (VALID_OUT),
        .READY_IN  (READY_IN)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Edges after the accept edge until the result is valid.
    function automatic int shift_extra(input int shamt);
`ifdef ALU_BARREL_EN
        return 0 + (shamt * 0);
`else
        return shamt + 1;
`endif
    endfunction

    // Issue one request, wait for its result, check it, then consume it.
    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_zero,
                         input logic exp_ileg, input int exp_extra);
        int cnt;
        READY_IN  = 1'b0;
        ALUSELECT = op;
        OP_A      = a;
        OP_B      = b;
        VALID_IN  = 1'b1;
        check({tag, ".ready_before"}, {31'd0, READY_OUT}, 32'd1);
        tick();
        // Inputs after the accept edge must have no effect.
        VALID_IN  = 1'b0;
        ALUSELECT = 4'b0111;
        OP_A      = 32'hDEAD_BEEF;
        OP_B      = 32'h0000_0003;
        cnt = 0;
        while (!VALID_OUT && cnt < 100) begin
            tick();
            cnt++;
        end
        check({tag, ".latency"}, cnt, exp_extra);
        check({tag, ".result"}, RESULT, exp_res);
        check({tag, ".zero"}, {31'd0, ZERO}, {31'd0, exp_zero});
        check({tag, ".ilegal"}, {31'd0, ILEGAL}, {31'd0, exp_ileg});
        check({tag, ".ready_busy"}, {31'd0, READY_OUT}, 32'd0);
        READY_IN = 1'b1;
        tick();
        check({tag, ".consumed"}, {31'd0, VALID_OUT}, 32'd0);
        check({tag, ".ready_after"}, {31'd0, READY_OUT}, 32'd1);
        READY_IN = 1'b0;
    endtask

    initial begin
        // Reset held for two edges with a pending request.
        RST_n     = 1'b0;
        VALID_IN  = 1'b1;
        ALUSELECT = 4'b0000;
        OP_A      = 32'h0000_0001;
        OP_B      = 32'h0000_0001;
        READY_IN  = 1'b1;
        tick();
        tick();
        check("rst.ready_out", {31'd0, READY_OUT}, 32'd1);
        check("rst.valid_out", {31'd0, VALID_OUT}, 32'd0);
        check("rst.result", RESULT, 32'h0);
        check("rst.zero", {31'd0, ZERO}, 32'd1);
        check("rst.ilegal", {31'd0, ILEGAL}, 32'd0);
        RST_n    = 1'b1;
        VALID_IN = 1'b0;
        tick();
        check("rst.no_accept", {31'd0, VALID_OUT}, 32'd0);
        check("rst.still_ready", {31'd0, READY_OUT}, 32'd1);

        // Single-edge operations.
        do_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 0);
        do_op("sub",      4'b0110, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 0);
        do_op("slt",      4'b0100, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0);
        do_op("sltu",     4'b1000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 0);
        do_op("and",      4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0, 0);
        do_op("or",       4'b0010, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 0);

        // Shifts.
        do_op("sll31",    4'b0011, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, shift_extra(31));
        do_op("sra4",     4'b1001, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, shift_extra(4));
        do_op("srl0",     4'b0101, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b0, 1'b0, shift_extra(0));
        do_op("srl4",     4'b0101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, shift_extra(4));

        // Illegal code, then a legal op clears the flag.
        do_op("illegal",  4'b1100, 32'd5, 32'd3, 32'h0000_0000, 1'b1, 1'b1, 0);
        do_op("add_clr",  4'b0000, 32'd2, 32'd3, 32'h0000_0005, 1'b0, 1'b0, 0);

        // Backpressure on an XOR result with stray requests.
        ALUSELECT = 4'b0111;
        OP_A      = 32'hFF00_FF00;
        OP_B      = 32'h0F0F_0F0F;
        VALID_IN  = 1'b1;
        READY_IN  = 1'b0;
        tick();
        ALUSELECT = 4'b0000;
        OP_A      = 32'h0000_0001;
        OP_B      = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            VALID_IN = (i != 1);
            check("bp.valid_out", {31'd0, VALID_OUT}, 32'd1);
            check("bp.result", RESULT, 32'hF00F_F00F);
            check("bp.ready_out", {31'd0, READY_OUT}, 32'd0);
            tick();
        end
        check("bp.held", RESULT, 32'hF00F_F00F);
        VALID_IN = 1'b0;
        READY_IN = 1'b1;
        tick();
        check("bp.released", {31'd0, VALID_OUT}, 32'd0);
        check("bp.idle", {31'd0, READY_OUT}, 32'd1);
        READY_IN = 1'b0;
        tick();
        check("bp.no_ghost", {31'd0, VALID_OUT}, 32'd0);

        // Reset in the middle of an SLL by 20, counter at 10.
        ALUSELECT = 4'b0011;
        OP_A      = 32'h0000_0001;
        OP_B      = 32'd20;
        VALID_IN  = 1'b1;
        tick();
        VALID_IN = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        RST_n = 1'b0;
        tick();
        check("midrst.ready_out", {31'd0, READY_OUT}, 32'd1);
        check("midrst.valid_out", {31'd0, VALID_OUT}, 32'd0);
        check("midrst.result", RESULT, 32'h0);
        check("midrst.zero", {31'd0, ZERO}, 32'd1);
        RST_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("midrst.discarded", {31'd0, VALID_OUT}, 32'd0);
        do_op("add_after", 4'b0000, 32'd7, 32'd8, 32'h0000_000F, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
